// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man maze/score logic.
package pacman_pkg;

    typedef enum logic [1:0] {
        PLAY,
        CLEAR_HOLD,
        RELOAD
    } score_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int unsigned MAP_TILES             = 1200;
    localparam int unsigned DEFAULT_TOTAL_PELLETS = 244;

endpackage

// File: rtl/pellet_score_if.sv
// Gameplay-side signals between the pellet map / video timing and the score tracker.
interface pellet_score_if #(
    parameter int unsigned SCORE_DIGITS = 5
);
    logic                      seen_pellet;
    logic                      frame_tick;
    logic [4*SCORE_DIGITS-1:0] score_bcd;
    logic [10:0]               pellets_left;
    logic [3:0]                level;
    logic                      level_clear;
    logic                      freeze;
    logic                      map_reload;

    modport master (
        output seen_pellet, frame_tick,
        input  score_bcd, pellets_left, level, level_clear, freeze, map_reload
    );

    modport slave (
        input  seen_pellet, frame_tick,
        output score_bcd, pellets_left, level, level_clear, freeze, map_reload
    );
endinterface

// File: rtl/pellet_score_bcd_incr.sv
// Combinational packed-BCD +1 with ripple carry; sat flags an all-nines input.
module bcd_incr
    import pacman_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] din,
    output logic [4*DIGITS-1:0] dout,
    output logic                sat
);
    always_comb begin
        logic       carry;
        bcd_digit_t d;
        dout  = '0;
        sat   = 1'b1;
        carry = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d = din[4*i +: 4];
            if (d != 4'd9)
                sat = 1'b0;
            if (carry) begin
                if (d == 4'd9) begin
                    dout[4*i +: 4] = 4'd0;
                end else begin
                    dout[4*i +: 4] = d + 4'd1;
                    carry          = 1'b0;
                end
            end else begin
                dout[4*i +: 4] = d;
            end
        end
    end
endmodule

// File: rtl/pellet_score.sv
// Score / pellets-remaining / level tracker with the level-clear freeze and map reload sequence.
module pellet_score
    import pacman_pkg::*;
#(
    parameter int unsigned TOTAL_PELLETS = DEFAULT_TOTAL_PELLETS,
    parameter int unsigned SCORE_DIGITS  = 5,
    parameter int unsigned HOLD_FRAMES   = 120,
    parameter int unsigned MAX_LEVEL     = 15
) (
    input  logic           Clk,
    input  logic           Reset,
    pellet_score_if.slave  bus
);
    localparam int unsigned HI     = SCORE_DIGITS - 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

    score_state_t      state_q, state_d;
    logic [4*HI-1:0]   score_q, score_inc;
    logic              score_sat;
    logic [10:0]       pellets_q;
    logic [3:0]        level_q;
    logic [HOLD_W-1:0] hold_q;
    logic              level_clear_q, map_reload_q;
    logic              eat;

    // Digit 0 is always zero, so only the tens-and-up digits are stored and incremented.
    bcd_incr #(.DIGITS(HI)) u_incr (
        .din  (score_q),
        .dout (score_inc),
        .sat  (score_sat)
    );

    always_comb begin
        state_d = state_q;
        eat     = 1'b0;
        case (state_q)
            PLAY: begin
                if (bus.seen_pellet && pellets_q != '0) begin
                    eat = 1'b1;
                    if (pellets_q == 11'd1)
                        state_d = CLEAR_HOLD;
                end
            end
            CLEAR_HOLD: begin
                if (bus.frame_tick && (hold_q + HOLD_W'(1)) == HOLD_W'(HOLD_FRAMES))
                    state_d = RELOAD;
            end
            RELOAD:  state_d = PLAY;
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            state_q <= PLAY;
        else
            state_q <= state_d;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            score_q       <= '0;
            pellets_q     <= 11'(TOTAL_PELLETS);
            level_q       <= 4'd1;
            hold_q        <= '0;
            level_clear_q <= 1'b0;
            map_reload_q  <= 1'b0;
        end else begin
            level_clear_q <= 1'b0;
            map_reload_q  <= 1'b0;
            if (eat) begin
                if (!score_sat)
                    score_q <= score_inc;
                pellets_q <= pellets_q - 11'd1;
            end
            if (state_q == PLAY && state_d == CLEAR_HOLD) begin
                level_clear_q <= 1'b1;
                hold_q        <= '0;
            end
            if (state_q == CLEAR_HOLD && bus.frame_tick)
                hold_q <= hold_q + HOLD_W'(1);
            // map_reload is registered, so it is raised on entry and is high throughout RELOAD.
            if (state_q == CLEAR_HOLD && state_d == RELOAD)
                map_reload_q <= 1'b1;
            if (state_q == RELOAD) begin
                pellets_q <= 11'(TOTAL_PELLETS);
                if (level_q < 4'(MAX_LEVEL))
                    level_q <= level_q + 4'd1;
            end
        end
    end

    assign bus.score_bcd    = {score_q, 4'h0};
    assign bus.pellets_left = pellets_q;
    assign bus.level        = level_q;
    assign bus.level_clear  = level_clear_q;
    assign bus.map_reload   = map_reload_q;
    assign bus.freeze       = (state_q == CLEAR_HOLD) || (state_q == RELOAD);

endmodule

// File: tb/tb_pellet_score.sv
// Scoreboard bench: default-size tracker plus a small 4-pellet / 2-digit / 2-level instance.
module tb_pellet_score;

    logic Clk = 1'b0;
    logic Reset_a, Reset_b;
    always #5 Clk = ~Clk;

    pellet_score_if #(.SCORE_DIGITS(5)) bus_a ();
    pellet_score_if #(.SCORE_DIGITS(2)) bus_b ();

    pellet_score #(
        .TOTAL_PELLETS(244), .SCORE_DIGITS(5), .HOLD_FRAMES(120), .MAX_LEVEL(15)
    ) dut_a (.Clk(Clk), .Reset(Reset_a), .bus(bus_a.slave));

    pellet_score #(
        .TOTAL_PELLETS(4), .SCORE_DIGITS(2), .HOLD_FRAMES(3), .MAX_LEVEL(2)
    ) dut_b (.Clk(Clk), .Reset(Reset_b), .bus(bus_b.slave));

    typedef struct {
        int          which;
        string       name;
        logic [19:0] score;
        logic [10:0] pl;
        logic [3:0]  lv;
        logic        lc;
        logic        frz;
        logic        mr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    function automatic logic [19:0] bcd(input int v);
        logic [19:0] r = '0;
        int          t = v;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Drive one cycle, then queue what the DUT must show after that edge.
    task automatic step(input int which, input logic sp, input logic ft, input string nm,
                        input int sc, input int pl, input int lv,
                        input logic lc, input logic frz, input logic mr);
        exp_t e;
        if (which == 0) begin
            bus_a.seen_pellet = sp; bus_a.frame_tick = ft;
        end else begin
            bus_b.seen_pellet = sp; bus_b.frame_tick = ft;
        end
        @(posedge Clk);
        #1;
        e.which = which; e.name = nm; e.score = bcd(sc); e.pl = 11'(pl); e.lv = 4'(lv);
        e.lc = lc; e.frz = frz; e.mr = mr;
        q.push_back(e);
    endtask

    initial begin
        exp_t        e;
        logic [19:0] a_sc;
        logic [10:0] a_pl;
        logic [3:0]  a_lv;
        logic        a_lc, a_frz, a_mr;
        forever begin
            @(negedge Clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.which == 0) begin
                    a_sc = bus_a.score_bcd; a_pl = bus_a.pellets_left; a_lv = bus_a.level;
                    a_lc = bus_a.level_clear; a_frz = bus_a.freeze; a_mr = bus_a.map_reload;
                end else begin
                    a_sc = 20'(bus_b.score_bcd); a_pl = bus_b.pellets_left; a_lv = bus_b.level;
                    a_lc = bus_b.level_clear; a_frz = bus_b.freeze; a_mr = bus_b.map_reload;
                end
                checks++;
                if (a_sc === e.score && a_pl === e.pl && a_lv === e.lv &&
                    a_lc === e.lc && a_frz === e.frz && a_mr === e.mr)
                    passed++;
                else
                    $display("FAIL %s: got score=%h left=%0d level=%0d clear=%b freeze=%b reload=%b, want score=%h left=%0d level=%0d clear=%b freeze=%b reload=%b",
                             e.name, a_sc, a_pl, a_lv, a_lc, a_frz, a_mr,
                             e.score, e.pl, e.lv, e.lc, e.frz, e.mr);
            end
        end
    end

    initial begin
        Reset_a = 1'b1; Reset_b = 1'b1;
        bus_a.seen_pellet = 1'b0; bus_a.frame_tick = 1'b0;
        bus_b.seen_pellet = 1'b0; bus_b.frame_tick = 1'b0;

        // default instance: reset, reset beating a pellet, isolated and back-to-back pellets
        step(0, 0, 0, "a_reset",      0, 244, 1, 0, 0, 0);
        step(0, 1, 0, "a_reset_wins", 0, 244, 1, 0, 0, 0);
        Reset_a = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step(0, 1, 0, "a_isolated",      i*10, 244-i, 1, 0, 0, 0);
            step(0, 0, 1, "a_isolated_idle", i*10, 244-i, 1, 0, 0, 0);
        end
        Reset_a = 1'b1;
        step(0, 0, 0, "a_reset2", 0, 244, 1, 0, 0, 0);
        Reset_a = 1'b0;
        for (int i = 1; i <= 12; i++)
            step(0, 1, (i % 3 == 0), "a_burst", i*10, 244-i, 1, 0, 0, 0);
        step(0, 0, 0, "a_burst_end", 120, 232, 1, 0, 0, 0);

        // small instance, level 1: clear, ignored pellets in hold/reload, reload
        step(1, 0, 0, "b_reset", 0, 4, 1, 0, 0, 0);
        Reset_b = 1'b0;
        step(1, 1, 0, "b_l1_eat1", 10, 3, 1, 0, 0, 0);
        step(1, 1, 0, "b_l1_eat2", 20, 2, 1, 0, 0, 0);
        step(1, 1, 0, "b_l1_eat3", 30, 1, 1, 0, 0, 0);
        step(1, 1, 1, "b_l1_clear", 40, 0, 1, 1, 1, 0);
        step(1, 1, 0, "b_hold_ignore", 40, 0, 1, 0, 1, 0);
        step(1, 0, 1, "b_hold_tick1", 40, 0, 1, 0, 1, 0);
        step(1, 1, 1, "b_hold_tick2", 40, 0, 1, 0, 1, 0);
        step(1, 0, 0, "b_hold_idle", 40, 0, 1, 0, 1, 0);
        step(1, 0, 1, "b_hold_tick3", 40, 0, 1, 0, 1, 1);
        step(1, 1, 1, "b_reload_ignore", 40, 4, 2, 0, 0, 0);
        step(1, 0, 0, "b_l2_start", 40, 4, 2, 0, 0, 0);

        // level 2: clear again, level saturates at 2
        step(1, 1, 0, "b_l2_eat1", 50, 3, 2, 0, 0, 0);
        step(1, 1, 0, "b_l2_eat2", 60, 2, 2, 0, 0, 0);
        step(1, 1, 0, "b_l2_eat3", 70, 1, 2, 0, 0, 0);
        step(1, 1, 0, "b_l2_clear", 80, 0, 2, 1, 1, 0);
        step(1, 0, 1, "b_l2_tick1", 80, 0, 2, 0, 1, 0);
        step(1, 0, 1, "b_l2_tick2", 80, 0, 2, 0, 1, 0);
        step(1, 0, 1, "b_l2_tick3", 80, 0, 2, 0, 1, 1);
        step(1, 0, 0, "b_level_sat", 80, 4, 2, 0, 0, 0);

        // level 3: score saturates at 90 with two digits
        step(1, 1, 0, "b_l3_eat1", 90, 3, 2, 0, 0, 0);
        step(1, 1, 0, "b_score_sat1", 90, 2, 2, 0, 0, 0);
        step(1, 1, 0, "b_score_sat2", 90, 1, 2, 0, 0, 0);
        step(1, 1, 0, "b_l3_clear", 90, 0, 2, 1, 1, 0);
        step(1, 0, 1, "b_l3_tick1", 90, 0, 2, 0, 1, 0);

        // reset mid-hold: full reset state, no reload pulse afterwards
        Reset_b = 1'b1;
        step(1, 0, 1, "b_reset_in_hold", 0, 4, 1, 0, 0, 0);
        Reset_b = 1'b0;
        for (int i = 0; i < 4; i++)
            step(1, 0, 1, "b_no_reload", 0, 4, 1, 0, 0, 0);

        bus_b.frame_tick = 1'b0;
        repeat (3) @(posedge Clk);
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pellet_score.md
# pellet_score

Score and level-progress tracker sitting directly downstream of the pellet map. Consumes the one-cycle `seen_pellet` pulse the pellet map raises when Pac-Man eats a pellet, keeps a BCD score and a pellets-remaining count, and runs the level-clear sequence. That sequence freezes gameplay for a fixed number of frames, then pulses `map_reload` back into the pellet map's reset so the food layout is reloaded for the next level.

## Interface
Parameters:
- `TOTAL_PELLETS`, default 244: pellets in the food map; reload value of `pellets_left`.
- `SCORE_DIGITS`, default 5: BCD digits in `score_bcd`.
- `HOLD_FRAMES`, default 120: `frame_tick` pulses spent in CLEAR_HOLD.
- `MAX_LEVEL`, default 15: level saturation value.

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high reset.
- `seen_pellet` in 1: pellet-eaten pulse from the pellet map; each cycle it is high counts as one pellet.
- `frame_tick` in 1: one-cycle pulse per video frame (vsync edge).
- `score_bcd` out 4*SCORE_DIGITS: score, packed BCD, digit 0 in bits [3:0].
- `pellets_left` out 11: pellets not yet eaten this level.
- `level` out 4: current level, starting at 1.
- `level_clear` out 1: one-cycle pulse when the last pellet is eaten.
- `freeze` out 1: high in CLEAR_HOLD and RELOAD; gates Pac-Man and ghost movement.
- `map_reload` out 1: one-cycle pulse; ORed into the pellet map's `Reset`.

## Operation
- FSM states:
  - PLAY, the reset state.
  - CLEAR_HOLD.
  - RELOAD.
- Reset values: `score_bcd`=0; `pellets_left`=TOTAL_PELLETS; `level`=1; `level_clear`=0; `map_reload`=0; `freeze`=0; hold counter=0; state PLAY.
- PLAY, on `seen_pellet`=1:
  - Score +10: digit 1 +1 with BCD carry into higher digits; digit 0 is always 0.
  - `pellets_left` −1.
  - If `pellets_left`==1 before the decrement: go to CLEAR_HOLD, pulse `level_clear`, clear the hold counter.
- Score saturation: when all digits 1..SCORE_DIGITS−1 are 9, the score holds at 99…90. No wrap.
- `seen_pellet` outside PLAY is ignored: no score change, no decrement.
- `seen_pellet` with `pellets_left`==0 cannot occur in PLAY. If it does, it is ignored; no underflow.
- CLEAR_HOLD: the counter increments on each `frame_tick`. On the tick that brings it to HOLD_FRAMES, go to RELOAD.
- RELOAD, exactly one cycle:
  - `map_reload`=1.
  - `pellets_left` <= TOTAL_PELLETS.
  - `level` <= min(level+1, MAX_LEVEL).
  - Next state PLAY.
- Score persists across levels; only `Reset` clears it.
- `freeze` is decoded combinationally from the state register.

## Timing
- All outputs except `freeze` are registered.
- Latency: `seen_pellet` high at edge N → `score_bcd`/`pellets_left` updated after edge N (visible in cycle N+1).
- `level_clear` is high in the cycle after the edge that consumed the last pellet; `freeze` rises in the same cycle.
- `seen_pellet` high on consecutive cycles: each cycle counts.
- `frame_tick` coinciding with the last-pellet edge: not counted toward the hold; counting starts the cycle after entry.
- `freeze` duration, measured from `level_clear`: HOLD_FRAMES frame ticks plus 1 cycle. `map_reload` is high in the last freeze cycle; `freeze` is low the cycle after `map_reload`.
- `Reset` mid-CLEAR_HOLD or mid-RELOAD: next cycle is the full reset state with no `map_reload` pulse. The pellet map has its own reset.
- `Reset` and `seen_pellet` together: `Reset` wins.

## Structure
- Shared package `pacman_pkg`:
  - `score_state_t` enum {PLAY, CLEAR_HOLD, RELOAD}.
  - `bcd_digit_t` (logic [3:0]).
  - `MAP_TILES`=1200.
  - Default TOTAL_PELLETS constant.
- Sub-module `bcd_incr`:
  - Combinational.
  - Parameterised by digit count.
  - Adds 1 to packed BCD with a carry chain.
  - `sat` output high when the input is all 9s.
- `pellet_score` instantiates `bcd_incr` on digits [SCORE_DIGITS−1:1].

## Test plan
- Reset, then 3 isolated `seen_pellet` pulses → `score_bcd`=0x00030, `pellets_left`=241, `freeze`=0.
- `seen_pellet` held high 12 consecutive cycles → score 0x00120, `pellets_left`=232; digit carry 9→10 is correct at the 10th pellet (0x00090→0x00100).
- TOTAL_PELLETS=4, HOLD_FRAMES=3: eat 4 → `level_clear` one cycle; extra `seen_pellet` during hold ignored; after 3 `frame_tick`s `map_reload` one cycle; then `level`=2, `pellets_left`=4, `freeze`=0, score 0x00040.
- Score preset near max (SCORE_DIGITS=2, 10 pellets) → score sticks at 0x90 with no wrap.
- `Reset` asserted during CLEAR_HOLD → next cycle: state PLAY, `level`=1, score 0, `map_reload` never pulses.
- Level saturation, MAX_LEVEL=2: clear the level twice → `level` stays 2.
